// File: rtl/multi_mem_if.sv
// Port bundle for multi_mem: byte-write port A, word-read port B.
// The master drives both request sides; the slave (the RAM) returns QB.
interface multi_mem_if #(
  parameter int AW    = 12,
  parameter int BW    = 10,
  parameter int LANES = 4
);
  logic [7:0]         DataInA;
  logic [AW-1:0]      AddressA;
  logic               WrA;
  logic               ClockEnA;
  logic [BW-1:0]      AddressB;
  logic               ClockEnB;
  logic [LANES*8-1:0] QB;

  // No handshake: a transfer happens on every rising edge whose enable is high.
  // ClockEnA&WrA commits a byte, and ClockEnB loads QB one edge later.
  modport master (
    output DataInA, AddressA, WrA, ClockEnA, AddressB, ClockEnB,
    input  QB
  );

  modport slave (
    input  DataInA, AddressA, WrA, ClockEnA, AddressB, ClockEnB,
    output QB
  );
endinterface

// File: rtl/multi_mem.sv
// Frame-buffer RAM: LANES byte banks; port A writes bytes, port B reads a row of all banks.
// Optional MULTIMEM_WRITE_BYPASS_EN forwards a same-edge write into QB (write-first).
module multi_mem #(
  parameter int PIXEL_WIDTH      = 64,
  parameter int PIXEL_HEIGHT     = 32,
  parameter int PIXEL_HALFHEIGHT = PIXEL_HEIGHT / 2,
  parameter int BYTES_PER_PIXEL  = 2,
  localparam int DEPTH = PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL,
  localparam int AW    = $clog2(DEPTH),
  localparam int LANES = (PIXEL_HEIGHT / PIXEL_HALFHEIGHT) * BYTES_PER_PIXEL,
  localparam int LB    = $clog2(LANES),
  localparam int BW    = AW - LB
) (
  input logic       Clock,
  input logic       Reset,
  multi_mem_if.slave bus
);

  // Every addressable row exists; out-of-range bytes are masked by the range checks.
  localparam int ROWS = 2 ** BW;
  localparam bit FULL = (DEPTH == (2 ** AW));

  logic [BW-1:0]      wr_row;
  logic [LB-1:0]      wr_bank;
  logic               wr_in_range;
  wire  [LANES*8-1:0] qb_w;

  assign wr_row  = bus.AddressA[AW-1:LB];
  assign wr_bank = bus.AddressA[LB-1:0];

  if (FULL) begin : g_wr_full
    assign wr_in_range = 1'b1;
  end else begin : g_wr_chk
    assign wr_in_range = ({1'b0, bus.AddressA} < (AW + 1)'(DEPTH));
  end

  for (genvar k = 0; k < LANES; k++) begin : g_bank
    logic [7:0] mem [ROWS] = '{default: 8'h00};
    logic       we;
    logic       rd_in_range;
    logic [7:0] rd_byte;
    logic [7:0] lane_q;

    assign we = bus.ClockEnA & bus.WrA & wr_in_range & (wr_bank == LB'(k));

    if (FULL) begin : g_rd_full
      assign rd_in_range = 1'b1;
    end else begin : g_rd_chk
      assign rd_in_range = ({1'b0, bus.AddressB, LB'(k)} < (AW + 1)'(DEPTH));
    end

    // Storage has no reset: Reset only blanks QB and blocks writes.
    always_ff @(posedge Clock) begin
      if (!Reset && we) begin
        mem[wr_row] <= bus.DataInA;
      end
    end

    always_comb begin
      rd_byte = mem[bus.AddressB];
`ifdef MULTIMEM_WRITE_BYPASS_EN
      if (we && (wr_row == bus.AddressB)) begin
        rd_byte = bus.DataInA;
      end
`endif
      if (!rd_in_range) begin
        rd_byte = 8'h00;
      end
    end

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        lane_q <= 8'h00;
      end else if (bus.ClockEnB) begin
        lane_q <= rd_byte;
      end
    end

    assign qb_w[8*k +: 8] = lane_q;
  end

  assign bus.QB = qb_w;

endmodule

// File: tb/tb_multi_mem.sv
// Directed bench for multi_mem: driver tasks push expected read words, a negedge monitor pops and compares.
module tb_multi_mem;

  localparam int AW    = 12;
  localparam int BW    = 10;
  localparam int LANES = 4;
  localparam int W     = LANES * 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic rd_fire;
  logic [W-1:0] exp_q[$];

  multi_mem_if #(.AW(AW), .BW(BW), .LANES(LANES)) bus ();

  multi_mem dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_fire <= bus.ClockEnB && !rst;

  always @(negedge clk) begin
    if (rd_fire === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", bus.QB);
      end else begin
        check("read", bus.QB, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.ClockEnA = 1'b0;
    bus.WrA      = 1'b0;
    bus.ClockEnB = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d, input logic en_a);
    @(negedge clk);
    bus.AddressA = a;
    bus.DataInA  = d;
    bus.WrA      = 1'b1;
    bus.ClockEnA = en_a;
    @(posedge clk);
    #1 idle();
  endtask

  task automatic rd(input logic [BW-1:0] a, input logic [W-1:0] exp);
    @(negedge clk);
    bus.AddressB = a;
    bus.ClockEnB = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 idle();
  endtask

  task automatic collide(input logic [AW-1:0] wa, input logic [7:0] d,
                         input logic [BW-1:0] ra, input logic [W-1:0] exp);
    @(negedge clk);
    bus.AddressA = wa;
    bus.DataInA  = d;
    bus.WrA      = 1'b1;
    bus.ClockEnA = 1'b1;
    bus.AddressB = ra;
    bus.ClockEnB = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 idle();
  endtask

  task automatic back_to_back_reads();
    @(negedge clk);
    bus.ClockEnB = 1'b1;
    bus.AddressB = 10'h000;
    exp_q.push_back(32'h44332211);
    @(negedge clk);
    bus.AddressB = 10'h1FF;
    exp_q.push_back(32'h5A000000);
    @(negedge clk);
    bus.AddressB = 10'h3FF;
    exp_q.push_back(32'h43450000);
    @(posedge clk);
    #1 idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.DataInA  = 8'h00;
    bus.AddressA = '0;
    bus.AddressB = '0;
    idle();

    #2 check("reset_qb_during", bus.QB, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check("reset_qb_after", bus.QB, 32'h0);

    rd(10'h3FF, 32'h00000000);

    wr(12'hFFF, 8'h41, 1'b1);
    wr(12'hFFE, 8'h42, 1'b1);
    rd(10'h3FF, 32'h41420000);

    // QB must hold with ClockEnB low even when AddressB moves.
    @(negedge clk) bus.AddressB = 10'h000;
    repeat (3) @(posedge clk);
    #1 check("hold_qb", bus.QB, 32'h41420000);

    wr(12'hFFF, 8'h43, 1'b1);
    rd(10'h3FF, 32'h43420000);

`ifdef MULTIMEM_WRITE_BYPASS_EN
    collide(12'hFFE, 8'h45, 10'h3FF, 32'h43450000);
`else
    collide(12'hFFE, 8'h45, 10'h3FF, 32'h43420000);
`endif
    rd(10'h3FF, 32'h43450000);

    wr(12'h7FF, 8'h5A, 1'b0);
    rd(10'h1FF, 32'h00000000);
    wr(12'h7FF, 8'h5A, 1'b1);
    rd(10'h1FF, 32'h5A000000);

    wr(12'h000, 8'h11, 1'b1);
    wr(12'h001, 8'h22, 1'b1);
    wr(12'h002, 8'h33, 1'b1);
    wr(12'h003, 8'h44, 1'b1);
    back_to_back_reads();

    // One-cycle reset pulse; memory contents survive it.
    @(negedge clk) rst = 1'b1;
    #1 check("pulse_qb_during", bus.QB, 32'h0);
    @(negedge clk) rst = 1'b0;
    #1 check("pulse_qb_after", bus.QB, 32'h0);
    rd(10'h3FF, 32'h43450000);

    // Reset asserted between edges while QB is nonzero, with a write pending.
    rd(10'h000, 32'h44332211);
    @(negedge clk);
    bus.AddressA = 12'h001;
    bus.DataInA  = 8'h99;
    bus.WrA      = 1'b1;
    bus.ClockEnA = 1'b1;
    #2 rst = 1'b1;
    #1 check("async_reset_qb", bus.QB, 32'h0);
    @(posedge clk);
    #1 idle();
    check("reset_hold_qb", bus.QB, 32'h0);
    @(negedge clk) rst = 1'b0;
    rd(10'h000, 32'h44332211);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
